pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline; drives the F and D register stall

---
 rtl/pipe_ctrl_pkg.sv | 31 +++
 rtl/pipe_hazard_ctrl_if.sv | 53 +++++
 rtl/pipe_hazard_ctrl_md_busy_timer.sv | 31 +++
 rtl/pipe_hazard_ctrl.sv | 110 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer and its HI/LO busy timer.
// Optional performance counters are enabled with the PIPE_HAZARD_PERF_EN macro.
package pipe_ctrl_pkg;

    localparam int unsigned REG_W        = 5;
    localparam int unsigned MULT_LAT_DEF = 5;
    localparam int unsigned DIV_LAT_DEF  = 10;
    localparam int unsigned CNT_W_DEF    = 4;
    localparam int unsigned PERF_STALL_W = 32;
    localparam int unsigned PERF_INT_W   = 16;

    typedef logic [REG_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FLUSH = 2'd2
    } int_state_e;

    // True when a producer destination feeds a source the ID instruction actually reads; $0 never matches.
    function automatic logic src_match(input reg_idx_t dst,
                                       input reg_idx_t rs,
                                       input reg_idx_t rt,
                                       input logic     use_rs,
                                       input logic     use_rt);
        return (dst != REG_ZERO) && ((use_rs && (rs == dst)) || (use_rt && (rt == dst)));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side view of the stall/flush sequencer: hazard sources in, stall/flush controls out.
// Performance counter signals exist only when PIPE_HAZARD_PERF_EN is defined.
interface pipe_hazard_ctrl_if;
    import pipe_ctrl_pkg::*;

    reg_idx_t rsD;
    reg_idx_t rtD;
    logic     useRsD;
    logic     useRtD;
    logic     BranchD;
    logic     mdUseD;
    logic     RegWriteE;
    logic     MemReadE;
    reg_idx_t WriteRegE;
    logic     MemReadM;
    reg_idx_t WriteRegM;
    logic     mdStartE;
    logic     mdIsDivE;
    logic     int_req;

    logic     stallF;
    logic     stallD;
    logic     flushD;
    logic     flushE;
    logic     exc_pc_sel;
    logic     int_ack;
    logic     md_busy;
`ifdef PIPE_HAZARD_PERF_EN
    logic [PERF_STALL_W-1:0] perf_stall_cnt;
    logic [PERF_INT_W-1:0]   perf_int_cnt;
`endif

    modport master (
        output rsD, rtD, useRsD, useRtD, BranchD, mdUseD,
        output RegWriteE, MemReadE, WriteRegE, MemReadM, WriteRegM,
        output mdStartE, mdIsDivE, int_req,
        input  stallF, stallD, flushD, flushE, exc_pc_sel, int_ack, md_busy
`ifdef PIPE_HAZARD_PERF_EN
        , input perf_stall_cnt, perf_int_cnt
`endif
    );

    modport slave (
        input  rsD, rtD, useRsD, useRtD, BranchD, mdUseD,
        input  RegWriteE, MemReadE, WriteRegE, MemReadM, WriteRegM,
        input  mdStartE, mdIsDivE, int_req,
        output stallF, stallD, flushD, flushE, exc_pc_sel, int_ack, md_busy
`ifdef PIPE_HAZARD_PERF_EN
        , output perf_stall_cnt, perf_int_cnt
`endif
    );

endinterface

// File: rtl/pipe_hazard_ctrl_md_busy_timer.sv
// HI/LO busy timer: loads the mult or div latency on issue and counts down to idle.
module md_busy_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    logic [CNT_W-1:0] count;

    // A start while still busy simply reloads; the pipeline is not expected to do that.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (start) begin
            count <= is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign busy = (count != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer: load-use, branch-operand and HI/LO hazards plus interrupt entry.
// Define PIPE_HAZARD_PERF_EN to add the stall-cycle and interrupt-entry performance counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    pipe_hazard_ctrl_if.slave  hz
);

    logic       lw_haz;
    logic       br_haz;
    logic       md_haz;
    logic       stall;
    logic       md_busy;
    logic       in_flush;
    logic       stall_d;
    int_state_e state;

    md_busy_timer #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CNT_W    (CNT_W)
    ) u_md_busy_timer (
        .clk    (clk),
        .reset  (reset),
        .start  (hz.mdStartE),
        .is_div (hz.mdIsDivE),
        .busy   (md_busy)
    );

    // Branches resolve in ID, so they also wait on EX ALU results and MEM loads.
    always_comb begin
        lw_haz = 1'b0;
        br_haz = 1'b0;
        md_haz = 1'b0;
        lw_haz = hz.MemReadE &
                 src_match(hz.WriteRegE, hz.rsD, hz.rtD, hz.useRsD, hz.useRtD);
        br_haz = hz.BranchD &
                 ((hz.RegWriteE & src_match(hz.WriteRegE, hz.rsD, hz.rtD, hz.useRsD, hz.useRtD)) |
                  (hz.MemReadM  & src_match(hz.WriteRegM, hz.rsD, hz.rtD, hz.useRsD, hz.useRtD)));
        md_haz = hz.mdUseD & md_busy;
    end

    assign stall = lw_haz | br_haz | md_haz;

    // Interrupt entry waits for a quiet pipeline and HI/LO unit, then flushes for exactly one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (hz.int_req) begin
                        state <= (stall || md_busy) ? ST_WAIT : ST_FLUSH;
                    end
                end
                ST_WAIT: begin
                    if (!hz.int_req) begin
                        state <= ST_IDLE;
                    end else if (!stall && !md_busy) begin
                        state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign in_flush = (state == ST_FLUSH);

    // The flush cycle wins over any hazard stall so the vector fetch is not held.
    assign stall_d       = stall & ~in_flush;
    assign hz.stallF     = stall_d;
    assign hz.stallD     = stall_d;
    assign hz.flushE     = stall | in_flush;
    assign hz.flushD     = in_flush;
    assign hz.exc_pc_sel = in_flush;
    assign hz.int_ack    = in_flush;
    assign hz.md_busy    = md_busy;

`ifdef PIPE_HAZARD_PERF_EN
    logic [PERF_STALL_W-1:0] stall_cnt;
    logic [PERF_INT_W-1:0]   int_cnt;

    // Stall cycles saturate; interrupt entries wrap. FLUSH lasts one cycle, so cycles equal entries.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            int_cnt   <= '0;
        end else begin
            if (stall_d && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + PERF_STALL_W'(1);
            end
            if (in_flush) begin
                int_cnt <= int_cnt + PERF_INT_W'(1);
            end
        end
    end

    assign hz.perf_stall_cnt = stall_cnt;
    assign hz.perf_int_cnt   = int_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: reference model feeds a scoreboard of per-cycle outputs.
module tb_pipe_hazard_ctrl;

    logic clk;
    logic reset;

    pipe_hazard_ctrl_if hz();

    pipe_hazard_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Output vector order: stallF, stallD, flushD, flushE, exc_pc_sel, int_ack, md_busy
    logic [6:0] sb[$];
    logic [6:0] last;

    int m_cnt;
    int m_st;   // 0 idle, 1 wait, 2 flush

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic ref_match(input logic [4:0] dst);
        return (dst != 5'd0) &&
               ((hz.useRsD && hz.rsD == dst) || (hz.useRtD && hz.rtD == dst));
    endfunction

    function automatic logic ref_stall();
        logic lw, br, md;
        lw = hz.MemReadE && ref_match(hz.WriteRegE);
        br = hz.BranchD && ((hz.RegWriteE && ref_match(hz.WriteRegE)) ||
                            (hz.MemReadM && ref_match(hz.WriteRegM)));
        md = hz.mdUseD && (m_cnt > 0);
        return lw || br || md;
    endfunction

    function automatic logic [6:0] model_out();
        logic st, fl, bz;
        st = ref_stall();
        fl = (m_st == 2);
        bz = (m_cnt > 0);
        return {st && !fl, st && !fl, fl, st || fl, fl, fl, bz};
    endfunction

    task automatic model_step();
        logic st, bz;
        if (!reset) begin
            m_st  = 0;
            m_cnt = 0;
            return;
        end
        st = ref_stall();
        bz = (m_cnt > 0);
        if (m_st == 0) begin
            if (hz.int_req) m_st = (st || bz) ? 1 : 2;
        end else if (m_st == 1) begin
            if (!hz.int_req) m_st = 0;
            else if (!st && !bz) m_st = 2;
        end else begin
            m_st = 0;
        end
        if (hz.mdStartE) m_cnt = hz.mdIsDivE ? 10 : 5;
        else if (m_cnt > 0) m_cnt = m_cnt - 1;
    endtask

    function automatic logic [6:0] observe();
        return {hz.stallF, hz.stallD, hz.flushD, hz.flushE, hz.exc_pc_sel, hz.int_ack, hz.md_busy};
    endfunction

    // One cycle: push expectation for current inputs, compare at negedge, advance across posedge.
    task automatic cyc(input string tag);
        sb.push_back(model_out());
        @(negedge clk);
        last = observe();
        check(tag, 32'(last), 32'(sb.pop_front()));
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        hz.rsD = 5'd0;      hz.rtD = 5'd0;
        hz.useRsD = 1'b0;   hz.useRtD = 1'b0;
        hz.BranchD = 1'b0;  hz.mdUseD = 1'b0;
        hz.RegWriteE = 1'b0; hz.MemReadE = 1'b0; hz.WriteRegE = 5'd0;
        hz.MemReadM = 1'b0; hz.WriteRegM = 5'd0;
        hz.mdStartE = 1'b0; hz.mdIsDivE = 1'b0;
        hz.int_req = 1'b0;
    endtask

    task automatic start_md(input logic is_div);
        quiet();
        hz.mdStartE = 1'b1;
        hz.mdIsDivE = is_div;
        cyc(is_div ? "div_start" : "mult_start");
        hz.mdStartE = 1'b0;
        hz.mdIsDivE = 1'b0;
    endtask

    initial begin
        int stalls, busy_fall, acks, ack_idx;
        quiet();
        m_st = 0;
        m_cnt = 0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc("reset_state");
        reset = 1'b1;
        cyc("idle");

        // Load-use through rs and through rt, then the instruction has moved on
        hz.MemReadE = 1'b1; hz.RegWriteE = 1'b1; hz.WriteRegE = 5'd1;
        hz.useRsD = 1'b1; hz.rsD = 5'd1;
        cyc("lw_use_rs");
        quiet();
        hz.MemReadM = 1'b1; hz.WriteRegM = 5'd1; hz.RegWriteE = 1'b1; hz.WriteRegE = 5'd7;
        cyc("lw_use_gone");
        quiet();
        hz.MemReadE = 1'b1; hz.WriteRegE = 5'd9; hz.useRtD = 1'b1; hz.rtD = 5'd9;
        cyc("lw_use_rt");
        hz.useRtD = 1'b0;
        cyc("lw_rt_unused");

        // Register zero never matches
        quiet();
        hz.MemReadE = 1'b1; hz.WriteRegE = 5'd0; hz.useRsD = 1'b1; hz.rsD = 5'd0;
        cyc("lw_reg0");

        // Branch operand hazards
        quiet();
        hz.BranchD = 1'b1; hz.useRsD = 1'b1; hz.rsD = 5'd3;
        hz.MemReadM = 1'b1; hz.WriteRegM = 5'd3;
        cyc("br_lw_mem");
        hz.MemReadM = 1'b0; hz.WriteRegM = 5'd0;
        hz.RegWriteE = 1'b1; hz.WriteRegE = 5'd3;
        cyc("br_alu_ex");
        hz.RegWriteE = 1'b0;
        hz.MemReadM = 1'b0; hz.WriteRegM = 5'd3;
        cyc("br_mem_noload");
        hz.BranchD = 1'b0; hz.RegWriteE = 1'b1; hz.WriteRegE = 5'd3;
        cyc("nonbr_alu_ex");

        // Divide then mfhi: exactly ten stall cycles
        start_md(1'b1);
        hz.mdUseD = 1'b1;
        stalls = 0;
        busy_fall = -1;
        for (int i = 0; i < 13; i++) begin
            cyc($sformatf("div_mfhi_%0d", i));
            if (last[5]) stalls++;
            if (!last[0] && busy_fall < 0) busy_fall = i;
        end
        check("div_stall_cycles", 32'(stalls), 32'd10);
        check("div_busy_fall", 32'(busy_fall), 32'd10);

        // Multiply, then a reload by a divide while busy
        start_md(1'b0);
        hz.mdUseD = 1'b1;
        stalls = 0;
        for (int i = 0; i < 7; i++) begin
            cyc($sformatf("mult_mflo_%0d", i));
            if (last[5]) stalls++;
        end
        check("mult_stall_cycles", 32'(stalls), 32'd5);
        start_md(1'b0);
        cyc("mult_busy");
        start_md(1'b1);
        for (int i = 0; i < 11; i++) cyc($sformatf("reload_%0d", i));

        // Interrupt while divide busy: wait, then one flush
        start_md(1'b1);
        hz.int_req = 1'b1;
        acks = 0;
        ack_idx = -1;
        for (int i = 0; i < 16; i++) begin
            cyc($sformatf("int_div_%0d", i));
            if (last[1]) begin
                acks++;
                if (ack_idx < 0) ack_idx = i;
                hz.int_req = 1'b0;
            end
        end
        check("int_div_acks", 32'(acks), 32'd1);
        check("int_div_ack_idx", 32'(ack_idx), 32'd11);

        // Clean interrupt: flush next cycle and overrides a coincident load-use stall
        quiet();
        hz.int_req = 1'b1;
        cyc("int_clean_0");
        hz.int_req = 1'b0;
        hz.MemReadE = 1'b1; hz.WriteRegE = 5'd4; hz.useRsD = 1'b1; hz.rsD = 5'd4;
        cyc("int_clean_flush");
        check("flush_beats_stall", 32'(last), 32'b0011110);
        cyc("int_clean_after");

        // Interrupt dropped while waiting: back to idle, no ack
        start_md(1'b0);
        hz.int_req = 1'b1;
        cyc("int_drop_0");
        hz.int_req = 1'b0;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            cyc($sformatf("int_drop_%0d", i + 1));
            if (last[1]) acks++;
        end
        check("int_drop_acks", 32'(acks), 32'd0);

        // Asynchronous reset in WAIT with count 6
        start_md(1'b1);
        hz.int_req = 1'b1;
        for (int i = 0; i < 4; i++) cyc($sformatf("rst_wait_%0d", i));
        #2;
        reset = 1'b0;
        m_st = 0;
        m_cnt = 0;
        #1;
        check("rst_async_outs", 32'(observe()), 32'd0);
        hz.int_req = 1'b0;
        cyc("rst_held");
        reset = 1'b1;
        acks = 0;
        for (int i = 0; i < 12; i++) begin
            cyc($sformatf("rst_after_%0d", i));
            if (last[1]) acks++;
        end
        check("rst_no_ack", 32'(acks), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
